// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, bit-time counter width,
// standard baud-rate divisors at 100 MHz and a parity helper.
package uart_pkg;

    localparam int unsigned BR_W = 19;

    // Clocks per bit at 100 MHz, shared with the baud decoder and transmitter
    localparam logic [BR_W-1:0] BAUD_300    = 19'd333_333;
    localparam logic [BR_W-1:0] BAUD_1200   = 19'd83_333;
    localparam logic [BR_W-1:0] BAUD_2400   = 19'd41_667;
    localparam logic [BR_W-1:0] BAUD_4800   = 19'd20_833;
    localparam logic [BR_W-1:0] BAUD_9600   = 19'd10_417;
    localparam logic [BR_W-1:0] BAUD_19200  = 19'd5_208;
    localparam logic [BR_W-1:0] BAUD_38400  = 19'd2_604;
    localparam logic [BR_W-1:0] BAUD_57600  = 19'd1_736;
    localparam logic [BR_W-1:0] BAUD_115200 = 19'd868;
    localparam logic [BR_W-1:0] BAUD_230400 = 19'd434;
    localparam logic [BR_W-1:0] BAUD_460800 = 19'd217;
    localparam logic [BR_W-1:0] BAUD_921600 = 19'd109;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    // Expected parity bit; unused upper data bits must already be zero
    function automatic logic exp_parity(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-time down-counter. A load of N-1 produces an expiry N clocks later;
// the counter then rests at zero with o_expire held high.
module uart_bit_timer #(
    parameter int unsigned W = uart_pkg::BR_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_expire
);

    logic [W-1:0] r_cnt;

    // Load has priority; otherwise count down and stop at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_expire = (r_cnt == '0);

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive engine: start detect, mid-bit sampling, parity/framing check
// and a read-to-clear host interface.
// Optional macro UART_RX_SYNC_EN adds a 2-flop synchroniser on rx, delaying
// every sample point and rx_rdy by two clocks.
module uart_rx_frame #(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned BR_W     = 19
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [BR_W-1:0] baud_rate,
    input  logic            eight,
    input  logic            pen,
    input  logic            ohel,
    input  logic            rx,
    input  logic            rx_read,
    output logic [7:0]      rx_data,
    output logic            rx_rdy,
    output logic            perr,
    output logic            ferr,
    output logic            ovf
);

    import uart_pkg::*;

    rx_state_t       r_state, w_state_next;
    logic            w_rx;
    logic            r_rx_prev;
    logic            w_start;
    logic            w_expire;
    logic            w_load;
    logic [BR_W-1:0] w_load_val;
    logic [BR_W-1:0] w_half;
    logic            w_last_bit;

    logic [BR_W-1:0] r_br;
    logic            r_eight, r_pen, r_ohel;
    logic [7:0]      r_shift;
    logic [2:0]      r_idx;
    logic            r_perr_int;
    logic            r_ferr_next;
    logic            r_done;

    logic [7:0]      r_rx_data;
    logic            r_rdy, r_perr, r_ferr, r_ovf;

`ifdef UART_RX_SYNC_EN
    logic [1:0] r_sync;

    // Two-flop synchroniser, idle-high after reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], rx};
        end
    end

    assign w_rx = r_sync[1];
`else
    assign w_rx = rx;
`endif

    // rx history: a start needs a high-to-low transition, so a line stuck low
    // after a break cannot retrigger
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_prev <= w_rx;
        end
    end

    assign w_start    = r_rx_prev & ~w_rx;
    // Half a bit from the start edge lands the first sample mid start bit
    assign w_half     = {1'b0, baud_rate[BR_W-1:1]} - BR_W'(1);
    assign w_last_bit = (r_idx == (r_eight ? 3'd7 : 3'd6));

    uart_bit_timer #(
        .W (BR_W)
    ) u_bit_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_expire   (w_expire)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and timer reload
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_load_val   = r_br - BR_W'(1);
        unique case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_state_next = START;
                    w_load       = 1'b1;
                    w_load_val   = w_half;
                end
            end
            START: begin
                if (w_expire) begin
                    if (w_rx) begin
                        w_state_next = IDLE;
                    end else begin
                        w_state_next = DATA;
                        w_load       = 1'b1;
                    end
                end
            end
            DATA: begin
                if (w_expire) begin
                    w_load = 1'b1;
                    if (w_last_bit) begin
                        w_state_next = r_pen ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (w_expire) begin
                    w_load       = 1'b1;
                    w_state_next = STOP;
                end
            end
            STOP: begin
                if (w_expire) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Frame datapath: config capture, shift register, parity and stop sampling
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_br        <= '0;
            r_eight     <= 1'b0;
            r_pen       <= 1'b0;
            r_ohel      <= 1'b0;
            r_shift     <= 8'h00;
            r_idx       <= 3'd0;
            r_perr_int  <= 1'b0;
            r_ferr_next <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= (r_state == STOP) && w_expire;
            if ((r_state == IDLE) && w_start) begin
                r_br       <= baud_rate;
                r_eight    <= eight;
                r_pen      <= pen;
                r_ohel     <= ohel;
                r_shift    <= 8'h00;
                r_perr_int <= 1'b0;
            end
            if ((r_state == START) && w_expire) begin
                r_idx <= 3'd0;
            end
            if ((r_state == DATA) && w_expire) begin
                r_shift[r_idx] <= w_rx;
                r_idx          <= r_idx + 3'd1;
            end
            if ((r_state == PARITY) && w_expire) begin
                r_perr_int <= (w_rx != exp_parity(r_shift, r_ohel));
            end
            if ((r_state == STOP) && w_expire) begin
                r_ferr_next <= ~w_rx;
            end
        end
    end

    // Host-facing registers; a completing frame takes priority over rx_read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_data <= 8'h00;
            r_rdy     <= 1'b0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
            r_ovf     <= 1'b0;
        end else if (r_done) begin
            r_rx_data <= r_shift;
            r_rdy     <= 1'b1;
            r_perr    <= r_perr_int;
            r_ferr    <= r_ferr_next;
            r_ovf     <= (r_ovf | r_rdy) & ~rx_read;
        end else if (rx_read) begin
            r_rdy  <= 1'b0;
            r_perr <= 1'b0;
            r_ferr <= 1'b0;
            r_ovf  <= 1'b0;
        end
    end

    assign rx_data = r_rx_data;
    assign rx_rdy  = r_rdy;
    assign perr    = r_perr;
    assign ferr    = r_ferr;
    assign ovf     = r_ovf;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Scoreboard bench for uart_rx_frame: stimulus pushes expected characters and
// completion times, a monitor pops and compares on every new rx_rdy event.
module tb_uart_rx_frame;

`ifdef UART_RX_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [18:0] baud_rate;
    logic        eight, pen, ohel, rx, rx_read;
    logic [7:0]  rx_data;
    logic        rx_rdy, perr, ferr, ovf;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       ovf;
        longint     cyc;
    } exp_t;

    exp_t   sb_q[$];
    longint cyc = 0;
    int     n_checks = 0;
    int     n_errors = 0;
    int     n_items = 0;

    uart_rx_frame #(
        .CLK_FREQ (100_000_000),
        .BR_W     (19)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .baud_rate (baud_rate),
        .eight     (eight),
        .pen       (pen),
        .ohel      (ohel),
        .rx        (rx),
        .rx_read   (rx_read),
        .rx_data   (rx_data),
        .rx_rdy    (rx_rdy),
        .perr      (perr),
        .ferr      (ferr),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s act=%0h exp=%0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Must be called at a negedge; drives one frame and queues its expectation
    task automatic send_frame(input logic [7:0] d, input int nbits, input bit use_par,
                              input bit odd, input bit par_bit, input bit stop_bit,
                              input int br, input bit e_perr, input bit e_ferr,
                              input bit e_ovf);
        exp_t e;
        int   lat;
        eight     = (nbits == 8);
        pen       = use_par;
        ohel      = odd;
        baud_rate = 19'(br);
        lat       = br / 2 + (nbits + int'(use_par) + 1) * br + 1 + SYNC_LAT;
        e.data    = (nbits == 8) ? d : {1'b0, d[6:0]};
        e.perr    = e_perr;
        e.ferr    = e_ferr;
        e.ovf     = e_ovf;
        e.cyc     = cyc + 1 + lat;
        sb_q.push_back(e);
        rx = 1'b0;
        repeat (br) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            rx = d[i];
            repeat (br) @(negedge clk);
        end
        if (use_par) begin
            rx = par_bit;
            repeat (br) @(negedge clk);
        end
        rx = stop_bit;
        repeat (br) @(negedge clk);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_read(input string tag);
        rx_read = 1'b1;
        @(negedge clk);
        rx_read = 1'b0;
        @(negedge clk);
        chk({tag, "_rdy_clr"}, 32'(rx_rdy), 32'd0);
        chk({tag, "_perr_clr"}, 32'(perr), 32'd0);
        chk({tag, "_ferr_clr"}, 32'(ferr), 32'd0);
        chk({tag, "_ovf_clr"}, 32'(ovf), 32'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_data"}, 32'(rx_data), 32'd0);
        chk({tag, "_rdy"}, 32'(rx_rdy), 32'd0);
        chk({tag, "_perr"}, 32'(perr), 32'd0);
        chk({tag, "_ferr"}, 32'(ferr), 32'd0);
        chk({tag, "_ovf"}, 32'(ovf), 32'd0);
    endtask

    // Monitor: a new character is rx_rdy rising or a change while rx_rdy stays set
    initial begin
        logic        prev_rdy;
        logic [10:0] prev_vec, cur;
        exp_t        e;
        prev_rdy = 1'b0;
        prev_vec = '0;
        forever begin
            @(posedge clk);
            #1;
            cur = {rx_data, perr, ferr, ovf};
            if (!rst && rx_rdy && (!prev_rdy || cur != prev_vec)) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_char act=%0h exp=none (cyc %0d)", rx_data, cyc);
                end else begin
                    e = sb_q.pop_front();
                    chk($sformatf("item%0d_data", n_items), 32'(rx_data), 32'(e.data));
                    chk($sformatf("item%0d_perr", n_items), 32'(perr), 32'(e.perr));
                    chk($sformatf("item%0d_ferr", n_items), 32'(ferr), 32'(e.ferr));
                    chk($sformatf("item%0d_ovf", n_items), 32'(ovf), 32'(e.ovf));
                    chk($sformatf("item%0d_cycle", n_items), 32'(cyc), 32'(e.cyc));
                    n_items++;
                end
            end
            prev_rdy = rx_rdy;
            prev_vec = cur;
        end
    end

    initial begin
        #400_000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        longint t;
        rst       = 1'b1;
        rx        = 1'b1;
        rx_read   = 1'b0;
        eight     = 1'b1;
        pen       = 1'b0;
        ohel      = 1'b0;
        baud_rate = 19'd16;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        idle(5);

        // Character pending, then reset mid-frame discards everything
        send_frame(8'hA5, 8, 0, 0, 0, 1, 16, 0, 0, 0);
        idle(4);
        rx = 1'b0;
        repeat (16) @(negedge clk);
        rx = 1'b1;
        repeat (16) @(negedge clk);
        rx = 1'b0;
        repeat (16) @(negedge clk);
        rx = 1'b1;
        repeat (16) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk_zero("mid_rst");
        rst = 1'b0;
        idle(5);
        send_frame(8'hA5, 8, 0, 0, 0, 1, 16, 0, 0, 0);
        idle(4);
        do_read("a5");

        // 8N1 0x5A; config inputs change mid-frame and must be ignored
        fork
            send_frame(8'h5A, 8, 0, 0, 0, 1, 16, 0, 0, 0);
            begin
                repeat (40) @(negedge clk);
                baud_rate = 19'd50;
                eight     = 1'b0;
                pen       = 1'b1;
            end
        join
        idle(4);
        do_read("5a");

        // 7E1 0x41: correct then wrong parity bit
        send_frame(8'h41, 7, 1, 0, 0, 1, 16, 0, 0, 0);
        idle(4);
        do_read("7e1_ok");
        send_frame(8'h41, 7, 1, 0, 1, 1, 16, 1, 0, 0);
        idle(4);
        do_read("7e1_bad");

        // Break: one zero character with ferr, no retrigger while held low
        send_frame(8'h00, 8, 0, 0, 0, 0, 16, 0, 1, 0);
        repeat (60) @(negedge clk);
        idle(20);
        do_read("break");

        // 4-clock glitch is a false start
        rx = 1'b0;
        repeat (4) @(negedge clk);
        idle(40);
        chk("glitch_rdy", 32'(rx_rdy), 32'd0);

        // Overrun, then rx_read colliding with completion of a bad-stop frame
        send_frame(8'h11, 8, 0, 0, 0, 1, 16, 0, 0, 0);
        idle(4);
        send_frame(8'h22, 8, 0, 0, 0, 1, 16, 0, 0, 1);
        idle(4);
        t = cyc;
        fork
            send_frame(8'h33, 8, 0, 0, 0, 0, 16, 0, 1, 0);
            begin
                while (cyc < t + 153 + SYNC_LAT) @(negedge clk);
                rx_read = 1'b1;
                @(negedge clk);
                rx_read = 1'b0;
            end
        join
        idle(20);
        chk("collide_rdy", 32'(rx_rdy), 32'd1);
        do_read("collide");

        // 8E1 parity error
        send_frame(8'h03, 8, 1, 0, 1, 1, 16, 1, 0, 0);
        idle(4);
        do_read("8e1_bad");

        // Real rate 921600: 8O1 0xFF with parity bit 1
        send_frame(8'hFF, 8, 1, 1, 1, 1, 109, 0, 0, 0);
        idle(10);
        do_read("8o1");

        for (int i = 0; i < 2000 && sb_q.size() != 0; i++) @(negedge clk);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
